// File: rtl/wdm_pkg.sv
// Shared types and constants for the WDM transmit row.
// The FSM encoding, preamble start bit and a small sizing helper live here.
package wdm_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2
    } tx_state_e;

    // First preamble bit; the pattern alternates from here.
    localparam logic PREAMBLE_START_BIT = 1'b1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/wdm_tx_lane.sv
// One WDM lane: word shift register, enable latch and registered serial bit,
// plus the mapping from the serial bit to the ring tuning drive.
module wdm_tx_lane #(
    parameter int  DataWidth = 8,
    parameter real ModDetune = 0.5
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_load,
    input  logic [DataWidth-1:0] i_word,
    input  logic                 i_en,
    input  logic                 i_shift,
    input  logic                 i_data_sel,
    input  logic                 i_pre_bit,
    output logic                 o_bit,
    output real                  o_tuning
);

    logic [DataWidth-1:0] sh_q, sh_d;
    logic                 en_q, en_d;
    logic                 bit_q, bit_d;

    // The output bit is derived from next-state values so it is registered
    // yet already shows the bit belonging to the cycle that the edge starts.
    always_comb begin
        sh_d = sh_q;
        en_d = en_q;
        if (i_load) begin
            sh_d = i_word;
            en_d = i_en;
        end else if (i_shift) begin
            sh_d = {sh_q[DataWidth-2:0], 1'b0};
        end
        bit_d = en_d & (i_data_sel ? sh_d[DataWidth-1] : i_pre_bit);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sh_q  <= '0;
            en_q  <= 1'b0;
            bit_q <= 1'b0;
        end else begin
            sh_q  <= sh_d;
            en_q  <= en_d;
            bit_q <= bit_d;
        end
    end

    assign o_bit    = bit_q;
    assign o_tuning = bit_q ? ModDetune : 0.0;

endmodule

// File: rtl/wdm_tx_row.sv
// WDM transmit row: one-entry holding buffer, shared IDLE/PREAMBLE/DATA
// sequencer and counter, driving NUM_CHANNEL lane serializers in lockstep.
module wdm_tx_row
    import wdm_pkg::*;
#(
    parameter int  NUM_CHANNEL = 8,
    parameter int  DataWidth   = 8,
    parameter int  PreambleLen = 4,
    parameter real ModDetune   = 0.5
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic                                  i_valid,
    output logic                                  o_ready,
    input  logic [NUM_CHANNEL-1:0][DataWidth-1:0] i_data,
    input  logic [NUM_CHANNEL-1:0]                i_ch_en,
    output logic [NUM_CHANNEL-1:0]                o_bit,
    output real                                   o_real_tuning_dist [NUM_CHANNEL],
    output logic                                  o_frame_start,
    output logic                                  o_busy,
    output tx_state_e                             o_dbg_state
);

    localparam int MaxLen = max_int(PreambleLen, DataWidth);
    localparam int CntW   = (MaxLen > 1) ? $clog2(MaxLen) : 1;
    localparam logic [CntW-1:0] PreLast  = CntW'(PreambleLen - 1);
    localparam logic [CntW-1:0] DataLast = CntW'(DataWidth - 1);

    tx_state_e                             state_q, state_d;
    logic [CntW-1:0]                       cnt_q, cnt_d;
    logic                                  buf_valid_q, buf_valid_d;
    logic [NUM_CHANNEL-1:0][DataWidth-1:0] buf_data_q, buf_data_d;
    logic [NUM_CHANNEL-1:0]                buf_en_q, buf_en_d;
    logic                                  frame_start_q, frame_start_d;
    logic                                  load, shift, accept, pre_bit, data_sel;

    // Handshake: a word is taken on an edge where i_valid and o_ready are both 1.
    assign o_ready = ~buf_valid_q & i_rst_n;
    assign accept  = i_valid & o_ready;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        load          = 1'b0;
        shift         = 1'b0;
        frame_start_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (buf_valid_q) begin
                    load          = 1'b1;
                    state_d       = PREAMBLE;
                    cnt_d         = '0;
                    frame_start_d = 1'b1;
                end
            end
            PREAMBLE: begin
                if (cnt_q == PreLast) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == DataLast) begin
                    // A buffered word continues the frame without a new preamble.
                    cnt_d = '0;
                    if (buf_valid_q) load = 1'b1;
                    else             state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    shift = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        buf_valid_d = buf_valid_q;
        buf_data_d  = buf_data_q;
        buf_en_d    = buf_en_q;
        if (load) buf_valid_d = 1'b0;
        if (accept) begin
            buf_valid_d = 1'b1;
            buf_data_d  = i_data;
            buf_en_d    = i_ch_en;
        end

        pre_bit  = (state_d == PREAMBLE) & (PREAMBLE_START_BIT ^ cnt_d[0]);
        data_sel = (state_d == DATA);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            buf_valid_q   <= 1'b0;
            buf_data_q    <= '0;
            buf_en_q      <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            buf_valid_q   <= buf_valid_d;
            buf_data_q    <= buf_data_d;
            buf_en_q      <= buf_en_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign o_frame_start = frame_start_q;
    assign o_busy        = (state_q != IDLE);
    assign o_dbg_state   = state_q;

    for (genvar g = 0; g < NUM_CHANNEL; g++) begin : g_lane
        wdm_tx_lane #(
            .DataWidth (DataWidth),
            .ModDetune (ModDetune)
        ) u_lane (
            .i_clk      (i_clk),
            .i_rst_n    (i_rst_n),
            .i_load     (load),
            .i_word     (buf_data_q[g]),
            .i_en       (buf_en_q[g]),
            .i_shift    (shift),
            .i_data_sel (data_sel),
            .i_pre_bit  (pre_bit),
            .o_bit      (o_bit[g]),
            .o_tuning   (o_real_tuning_dist[g])
        );
    end

endmodule
